vdb_led_bank: RTL and testbench
===============================

VDB_LED_BANK -- requirements
Module: vdb_led_bank

Interface
REQ-001 Parameter CHANNELS, default 8, SHALL set the number of LED channels (1..32).
REQ-002 Parameter PWM_BITS, default 8, SHALL set the width of the PWM counter and the duty value.
REQ-003 Parameter PRESCALE, default 4, SHALL set the clk cycles per PWM counter step (>=1).
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in  in  CHANNELS  per-channel direct drive level.
REQ-007 cfg_we  in  1  configuration write strobe, one write per cycle.
REQ-008 cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel of the write.
REQ-009 cfg_mode  in  2  mode: 0 DIRECT, 1 OFF, 2 ON, 3 PWM.
REQ-010 cfg_duty  in  PWM_BITS  PWM duty for the target channel.
REQ-011 led  out  CHANNELS  registered effective LED state.
REQ-012 evt_valid  out  1  a state-change event is pending.
REQ-013 evt_ready  in  1  the consumer accepts the event.
REQ-014 evt_ch  out  $clog2(CHANNELS) (min 1)  channel of the presented event.
REQ-015 evt_state  out  1  new state of that channel (1 = on).
REQ-016 evt_ovf  out  1  sticky flag for a coalesced (lost) event.
REQ-017 ovf_clr  in  1  clears evt_ovf.

Function
REQ-018 A cfg_we write SHALL update mode[cfg_ch] and duty[cfg_ch] at the clock edge; a cfg_ch >= CHANNELS SHALL be ignored.
REQ-019 Prescaler: it SHALL count 0..PRESCALE-1 and wrap; on wrap, pwm_cnt SHALL increment modulo 2^PWM_BITS.
REQ-020 Next state per channel: DIRECT = in[ch]; OFF = 0; ON = 1; PWM = (pwm_cnt < duty[ch]).
REQ-021 Consequences: duty 0 SHALL give always-off; duty 2^PWM_BITS-1 SHALL give off exactly one count per period.
REQ-022 led[ch] SHALL register the next state; latency from in, a cfg write or pwm_cnt to led SHALL be 1 clk.
REQ-023 Change: a change of led[ch] (next != current) SHALL set pend[ch] and pstate[ch] = next.
REQ-024 evt_valid SHALL be OR of pend; evt_ch SHALL be the lowest pending index; evt_state SHALL be pstate[evt_ch]; all three SHALL come from registers only.
REQ-025 A transfer (evt_valid & evt_ready) SHALL clear pend[evt_ch] at that edge.
REQ-026 If the transferred channel changes in the same cycle, pend SHALL stay set, pstate SHALL take the new state, and evt_ovf SHALL NOT be set.
REQ-027 A change on an already-pending channel with no transfer of that channel SHALL overwrite pstate and set evt_ovf.
REQ-028 While evt_valid is high and evt_ready is low, evt_ch and evt_state SHALL remain stable unless a lower-index channel becomes pending or REQ-027 applies.
REQ-029 evt_ovf SHALL clear on ovf_clr; if ovf_clr and a new overflow occur in the same cycle, evt_ovf SHALL be set.
REQ-030 Multiple channels changing in one cycle SHALL each set their own pend; no event SHALL be dropped.

Reset
REQ-031 While rst is high, the following SHALL be asynchronously zero: led, mode (= DIRECT), duty, prescaler, pwm_cnt, pend, pstate and evt_ovf.
REQ-032 Reset SHALL generate no events; the first evaluation after release SHALL compare against led = 0.
REQ-033 Reset asserted mid-PWM-period or with events pending SHALL discard all state; evt_valid SHALL be low the cycle after assertion.

Verification
REQ-034 DIRECT, in[2] 0->1 then 1->0, evt_ready=1 -> led[2] follows 1 clk later; events (ch2,1) then (ch2,0).
REQ-035 Ch0 PWM duty=64, PWM_BITS=8, PRESCALE=4 -> led[0] high 256 clk per 1024-clk period; duty=0 gives no edges.
REQ-036 evt_ready=0, in[5] and in[1] rise together -> evt_ch=1 first; raising ready then gives ch1, then ch5.
REQ-037 evt_ready=0, in[3] toggles 0->1->0 -> evt_state=0 and evt_ovf=1; ovf_clr -> evt_ovf=0.
REQ-038 Ch4 set to ON, then rst pulsed mid-stream -> led=0, evt_valid=0, mode DIRECT; with in=0 no events after release.

Source files
------------

// File: rtl/vdb_led_bank.sv
// LED channel bank: per-channel DIRECT/OFF/ON/PWM drive with a registered LED
// vector and a coalescing, lowest-index-first state-change event port.
module vdb_led_bank #(
  parameter int CHANNELS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [CHANNELS-1:0] led,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CH_W-1:0]     evt_ch,
  output logic                evt_state,
  output logic                evt_ovf,
  input  logic                ovf_clr
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_OFF    = 2'd1,
    MODE_ON     = 2'd2,
    MODE_PWM    = 2'd3
  } mode_t;

  mode_t               mode     [CHANNELS];
  logic [PWM_BITS-1:0] duty     [CHANNELS];
  mode_t               eff_mode [CHANNELS];
  logic [PWM_BITS-1:0] eff_duty [CHANNELS];

  logic [PS_W-1:0]     presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [CHANNELS-1:0] nxt;
  logic [CHANNELS-1:0] chg;
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] pstate;
  logic [CHANNELS-1:0] sel_low;
  logic [CHANNELS-1:0] xfer_sel;
  logic [CHANNELS-1:0] ovf_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (presc == PS_W'(PRESCALE - 1)) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Channel indices beyond CHANNELS never match, so such writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode[i] <= MODE_DIRECT;
        duty[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_ch == CH_W'(i)) begin
          mode[i] <= mode_t'(cfg_mode);
          duty[i] <= cfg_duty;
        end
      end
    end
  end

  // A write in flight is bypassed so the LED reflects it one clock later.
  always_comb begin
    nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      eff_mode[i] = mode[i];
      eff_duty[i] = duty[i];
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        eff_mode[i] = mode_t'(cfg_mode);
        eff_duty[i] = cfg_duty;
      end
      case (eff_mode[i])
        MODE_DIRECT: nxt[i] = in[i];
        MODE_OFF:    nxt[i] = 1'b0;
        MODE_ON:     nxt[i] = 1'b1;
        default:     nxt[i] = (pwm_cnt < eff_duty[i]);
      endcase
    end
  end

  assign chg = nxt ^ led;

  always_comb begin
    evt_ch    = '0;
    evt_state = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        evt_ch    = CH_W'(i);
        evt_state = pstate[i];
      end
    end
  end

  assign evt_valid = |pend;
  assign sel_low   = pend & (~pend + 1'b1);
  assign xfer_sel  = (evt_valid && evt_ready) ? sel_low : '0;
  // A change on the channel being handed off re-arms it rather than losing data.
  assign ovf_set   = chg & pend & ~xfer_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led     <= '0;
      pend    <= '0;
      pstate  <= '0;
      evt_ovf <= 1'b0;
    end else begin
      led <= nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        if (chg[i]) begin
          pend[i]   <= 1'b1;
          pstate[i] <= nxt[i];
        end else if (xfer_sel[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (|ovf_set) begin
        evt_ovf <= 1'b1;
      end else if (ovf_clr) begin
        evt_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vdb_led_bank.sv
// Scoreboard bench for vdb_led_bank: a record-queue reference model predicts
// LED levels and pending events; a negedge monitor compares the DUT against it.
module tb_vdb_led_bank;

  localparam int CH = 6;
  localparam int PB = 8;
  localparam int PS = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] in_v;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [1:0]    cfg_mode;
  logic [PB-1:0] cfg_duty;
  logic [CH-1:0] led;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_ch;
  logic          evt_state;
  logic          evt_ovf;
  logic          ovf_clr;

  vdb_led_bank #(.CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .in(in_v),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
    .led(led), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_state(evt_state), .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: configuration arrays, cycle count since reset, and a
  // queue of pending {channel, latest state} records.
  typedef struct { int ch; bit st; } ev_t;
  ev_t           pq[$];
  int            m_mode [CH];
  int            m_duty [CH];
  logic [CH-1:0] m_led;
  bit            m_ovf;
  int            t;
  int            k, pwm_m, found, ci;
  bit            nb, ovf_new;

  function automatic int min_idx();
    int r = -1;
    foreach (pq[j]) if (r < 0 || pq[j].ch < pq[r].ch) r = j;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = 0;
        m_duty[c] = 0;
      end
      m_led = '0;
      m_ovf = 1'b0;
      t     = 0;
      pq.delete();
      chk("rst_led", int'(led), 0);
      chk("rst_evt_valid", int'(evt_valid), 0);
    end else begin
      chk("led", int'(led), int'(m_led));
      chk("evt_ovf", int'(evt_ovf), int'(m_ovf));
      chk("evt_valid", int'(evt_valid), int'(pq.size() != 0));
      k = min_idx();
      if (k >= 0) begin
        chk("evt_ch", int'(evt_ch), pq[k].ch);
        chk("evt_state", int'(evt_state), int'(pq[k].st));
        if (evt_ready) pq.delete(k);
      end
      ci = int'(cfg_ch);
      if (cfg_we && ci < CH) begin
        m_mode[ci] = int'(cfg_mode);
        m_duty[ci] = int'(cfg_duty);
      end
      pwm_m   = (t / PS) % (1 << PB);
      ovf_new = 1'b0;
      for (int c = 0; c < CH; c++) begin
        case (m_mode[c])
          0:       nb = in_v[c];
          1:       nb = 1'b0;
          2:       nb = 1'b1;
          default: nb = (pwm_m < m_duty[c]);
        endcase
        if (nb != m_led[c]) begin
          found = -1;
          foreach (pq[j]) if (pq[j].ch == c) found = j;
          if (found >= 0) begin
            pq[found].st = nb;
            ovf_new = 1'b1;
          end else begin
            pq.push_back(ev_t'{ch: c, st: nb});
          end
          m_led[c] = nb;
        end
      end
      if (ovf_new) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      t++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int mode, input int duty);
    cfg_we   = 1'b1;
    cfg_ch   = CW'(ch);
    cfg_mode = 2'(mode);
    cfg_duty = PB'(duty);
    step();
    cfg_we = 1'b0;
  endtask

  int hi, edges, lows, vcnt, w;
  logic prev;

  initial begin
    rst = 1'b1; in_v = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_duty = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Direct drive follows input one clock later, events in order.
    in_v[2] = 1'b1; step(); step();
    chk("direct_rise_led2", int'(led[2]), 1);
    in_v[2] = 1'b0; step(); step();
    chk("direct_fall_led2", int'(led[2]), 0);

    // PWM duty 64: 256 high clocks per 1024-clock period.
    wr(0, 3, 64);
    repeat (8) step();
    hi = 0;
    repeat (1024) begin hi += int'(led[0]); step(); end
    chk("pwm64_high_clks", hi, 256);
    wr(0, 3, 0);
    repeat (4) step();
    edges = 0; prev = led[0];
    repeat (1024) begin
      if (led[0] != prev) edges++;
      prev = led[0];
      step();
    end
    chk("pwm0_edges", edges, 0);
    chk("pwm0_level", int'(led[0]), 0);
    wr(0, 3, 255);
    repeat (4) step();
    lows = 0;
    repeat (1024) begin lows += int'(!led[0]); step(); end
    chk("pwm255_low_clks", lows, PS);
    wr(0, 0, 0);
    repeat (4) step();

    // Simultaneous rises are presented lowest index first.
    evt_ready = 1'b0;
    in_v[5] = 1'b1; in_v[1] = 1'b1;
    step(); step();
    chk("simul_first_ch", int'(evt_ch), 1);
    evt_ready = 1'b1;
    step();
    chk("simul_second_ch", int'(evt_ch), 5);
    step();
    chk("simul_drained", int'(evt_valid), 0);
    in_v = '0;
    repeat (4) step();

    // Coalesced toggle sets the overflow flag; ovf_clr clears it.
    evt_ready = 1'b0;
    in_v[3] = 1'b1; step();
    in_v[3] = 1'b0; step(); step();
    chk("coal_ch", int'(evt_ch), 3);
    chk("coal_state", int'(evt_state), 0);
    chk("coal_ovf", int'(evt_ovf), 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_cleared", int'(evt_ovf), 0);
    evt_ready = 1'b1;
    repeat (3) step();

    // Reset mid-stream discards mode and pending events.
    wr(4, 2, 0);
    evt_ready = 1'b0; in_v = 6'b000011;
    repeat (3) step();
    rst = 1'b1; step();
    chk("rst_mid_led", int'(led), 0);
    chk("rst_mid_valid", int'(evt_valid), 0);
    rst = 1'b0; in_v = '0; evt_ready = 1'b1;
    vcnt = 0;
    repeat (20) begin vcnt += int'(evt_valid); step(); end
    chk("post_rst_no_events", vcnt, 0);
    chk("post_rst_led4_direct", int'(led[4]), 0);

    // Randomized traffic, including out-of-range channel writes.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) in_v = CH'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_ch    = CW'($urandom_range(0, 7));
      cfg_mode  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       cfg_duty = '0;
        1:       cfg_duty = '1;
        default: cfg_duty = PB'($urandom);
      endcase
      step();
    end
    cfg_we = 1'b0; ovf_clr = 1'b0;

    // Quiesce and make sure every predicted event has been delivered.
    in_v = '0; evt_ready = 1'b1;
    for (int c = 0; c < CH; c++) wr(c, 1, 0);
    w = 0;
    while (evt_valid && w < 200) begin step(); w++; end
    step();
    chk("drain_valid", int'(evt_valid), 0);
    chk("drain_model_empty", pq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
